// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_stream
//  Purpose  : Drains words from an upstream synchronous FIFO (one-cycle read
//             latency) into a valid/ready stream. A 2-entry in-order buffer
//             absorbs the read latency so the stream can run at one word per
//             cycle. Dropping en finishes delivery of buffered and in-flight
//             words before the block returns to idle.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             en              - enable reading (low = graceful drain)
//             fifo_empty      - upstream FIFO empty flag
//             fifo_rd_en      - upstream FIFO read strobe
//             fifo_data       - upstream FIFO read data (valid 1 cycle later)
//             m_valid/m_ready - stream handshake
//             m_data          - stream data (oldest buffered word)
//             busy            - high whenever not idle
//             xfer_count      - completed stream transfers (wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [1:0]            r_occ;
    logic [1:0]            w_occ_nxt;
    logic                  r_inflight;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_buf0;      // head entry
    logic [DATA_WIDTH-1:0] r_buf1;      // tail entry when two are held
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_pop;
    logic [2:0]            w_level;
    logic                  w_room;

    assign w_pop   = r_valid & m_ready;
    // Words already committed to the buffer: stored ones plus the one in flight.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight};
    // (level - pop) < 2, rearranged to avoid an unsigned underflow.
    assign w_room  = w_level < (3'd2 + {2'b00, w_pop});

    assign fifo_rd_en = !rst && (r_state == c_RUN) && !fifo_empty && w_room;

    assign m_valid    = r_valid;
    assign m_data     = r_buf0;
    assign busy       = (r_state != c_IDLE);
    assign xfer_count = r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (en) w_state_nxt = c_RUN;
            c_RUN:   if (!en) w_state_nxt = c_DRAIN;
            c_DRAIN: begin
                if (en)
                    w_state_nxt = c_RUN;
                else if ((r_occ == 2'd0) && !r_inflight)
                    w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_occ_nxt = r_occ;
        case ({r_inflight, w_pop})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;   // idle, or capture and pop together
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= fifo_rd_en;
            r_occ      <= w_occ_nxt;
            r_valid    <= (w_occ_nxt != 2'd0);

            // Head: on a pop it takes the next-oldest word, which is the
            // arriving word if only one was held; otherwise it is only
            // written when an arriving word lands in an empty buffer.
            if (w_pop)
                r_buf0 <= (r_inflight && (r_occ == 2'd1)) ? fifo_data : r_buf1;
            else if (r_inflight && (r_occ == 2'd0))
                r_buf0 <= fifo_data;

            // Tail: the arriving word lands here when it would be the second
            // entry after this edge's pop (if any).
            if (r_inflight && (w_pop ? (r_occ == 2'd2) : (r_occ == 2'd1)))
                r_buf1 <= fifo_data;

            if (w_pop)
                r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_stream
//  Purpose  : Self-checking bench for fifo_rd_stream. Models the upstream
//             synchronous FIFO, scores every stream transfer against the
//             order words were pushed, and runs directed scenarios (latency,
//             back-pressure, drain, reset mid-flight, counter wrap).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic [CW-1:0] xfer_count;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    // Upstream FIFO model: circular store, data valid the cycle after a read.
    logic [DW-1:0] mem [256];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr & 255];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int            n_checks  = 0;
    int            n_pass    = 0;
    int            exp_idx   = 0;   // index of the next word the stream owes
    int            outst     = 0;   // words read from FIFO but not yet delivered
    logic [CW-1:0] model_cnt = '0;
    int            guard;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic push(input logic [DW-1:0] d);
        mem[wr_ptr & 255] = d;
        wr_ptr++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: predicts what happens at the coming edge from the
    // settled signal values, then checks order, count and buffering bound.
    always @(negedge clk) begin
        if (rst) begin
            model_cnt = '0;
            outst     = 0;
            exp_idx   = rd_ptr;   // anything already taken from the FIFO is lost
            check("rd_en_during_rst", {31'd0, fifo_rd_en}, 32'd0);
        end else begin
            check("xfer_count", {16'd0, xfer_count}, {16'd0, model_cnt});
            if (!busy)
                check("rd_en_when_idle", {31'd0, fifo_rd_en}, 32'd0);
            if (fifo_empty)
                check("rd_en_when_empty", {31'd0, fifo_rd_en}, 32'd0);
            if (fifo_rd_en)
                outst++;
            if (m_valid && m_ready) begin
                check("stream_data", m_data, mem[exp_idx & 255]);
                exp_idx++;
                outst--;
                model_cnt++;
            end
            check("buffer_bound", {31'd0, (outst >= 0 && outst <= 2)}, 32'd1);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; m_ready = 1'b0;
        tick(); tick();
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_xfer_count", {16'd0, xfer_count}, 32'd0);
        check("rst_m_data", m_data, 32'd0);
        rst = 1'b0;
        tick();

        // Preloaded FIFO, full-rate streaming.
        for (int i = 0; i < 8; i++) push(32'hA0 + i);
        m_ready = 1'b1; en = 1'b1;
        tick();
        check("A_busy", {31'd0, busy}, 32'd1);
        check("A_rd_en_first", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        check("A_valid_cycle2", {31'd0, m_valid}, 32'd0);
        tick();
        check("A_valid_cycle3", {31'd0, m_valid}, 32'd1);
        check("A_first_word", m_data, 32'hA0);
        for (int k = 1; k < 8; k++) begin
            tick();
            check("A_stream_valid", {31'd0, m_valid}, 32'd1);
            check("A_stream_word", m_data, 32'hA0 + k);
        end
        check("A_rd_en_empty", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        check("A_valid_end", {31'd0, m_valid}, 32'd0);
        check("A_count", {16'd0, xfer_count}, 32'd8);
        en = 1'b0;
        tick(); tick();
        check("A_idle", {31'd0, busy}, 32'd0);

        // Back-pressure: only two reads while stalled, then gap-free release.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(32'hB0 + i);
        en = 1'b1;
        repeat (6) tick();
        check("B_fifo_left", wr_ptr - rd_ptr, 32'd3);
        check("B_valid", {31'd0, m_valid}, 32'd1);
        check("B_hold_word", m_data, 32'hB0);
        repeat (3) tick();
        check("B_stable_word", m_data, 32'hB0);
        check("B_fifo_still", wr_ptr - rd_ptr, 32'd3);
        m_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("B_release_valid", {31'd0, m_valid}, 32'd1);
            check("B_release_word", m_data, 32'hB0 + k);
        end
        tick();
        check("B_valid_end", {31'd0, m_valid}, 32'd0);
        check("B_count", {16'd0, xfer_count}, 32'd13);
        en = 1'b0;
        tick(); tick();
        check("B_idle", {31'd0, busy}, 32'd0);

        // Graceful drain with words left behind in the FIFO.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(32'hC0 + i);
        en = 1'b1;
        repeat (6) tick();
        check("C_valid", {31'd0, m_valid}, 32'd1);
        check("C_fifo_left", wr_ptr - rd_ptr, 32'd4);
        en = 1'b0;
        tick();
        check("C_drain_busy", {31'd0, busy}, 32'd1);
        check("C_drain_no_rd", {31'd0, fifo_rd_en}, 32'd0);
        m_ready = 1'b1;
        tick();
        check("C_second_word", m_data, 32'hC1);
        tick();
        check("C_valid_end", {31'd0, m_valid}, 32'd0);
        tick();
        check("C_idle", {31'd0, busy}, 32'd0);
        check("C_fifo_kept", wr_ptr - rd_ptr, 32'd4);
        check("C_count", {16'd0, xfer_count}, 32'd15);

        // Toggling ready with a continuously fed FIFO, then random traffic.
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m_ready = ((i % 2) == 0);
            if (wr_ptr - rd_ptr < 4) push($urandom);
            tick();
        end
        for (int i = 0; i < 200; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0 && wr_ptr - rd_ptr < 6) push($urandom);
            tick();
        end
        m_ready = 1'b1;
        guard = 0;
        while (!(fifo_empty && !m_valid) && guard < 50) begin
            tick();
            guard++;
        end
        check("D_drain_bound", {31'd0, guard < 50}, 32'd1);
        repeat (3) tick();
        en = 1'b0;
        tick(); tick();
        check("D_idle", {31'd0, busy}, 32'd0);
        check("D_all_delivered", exp_idx, wr_ptr);

        // Reset with one word buffered and one in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(32'hE0 + i);
        en = 1'b1;
        tick();
        check("E_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        tick(); tick();
        check("E_valid_pre", {31'd0, m_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("E_rd_en_in_rst", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        check("E_valid", {31'd0, m_valid}, 32'd0);
        check("E_busy", {31'd0, busy}, 32'd0);
        check("E_count", {16'd0, xfer_count}, 32'd0);
        check("E_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("E_m_data", m_data, 32'd0);
        rst = 1'b0; en = 1'b0;
        tick();
        check("E_fifo_left", wr_ptr - rd_ptr, 32'd1);
        en = 1'b1; m_ready = 1'b1;
        repeat (6) tick();
        en = 1'b0;
        repeat (3) tick();
        check("E_after_count", {16'd0, xfer_count}, 32'd1);

        // Run the counter up to its maximum, then one more transfer wraps it.
        en = 1'b1; m_ready = 1'b1;
        guard = 0;
        while (model_cnt != 16'hFFFF && guard < 70000) begin
            if (wr_ptr - rd_ptr < 4) push($urandom);
            tick();
            guard++;
        end
        check("F_reach_bound", {31'd0, guard < 70000}, 32'd1);
        check("F_count_max", {16'd0, xfer_count}, 32'h0000FFFF);
        check("F_valid", {31'd0, m_valid}, 32'd1);
        tick();
        check("F_count_wrap", {16'd0, xfer_count}, 32'd0);
        guard = 0;
        while (!(fifo_empty && !m_valid) && guard < 50) begin
            tick();
            guard++;
        end
        check("F_drain_bound", {31'd0, guard < 50}, 32'd1);
        repeat (3) tick();
        en = 1'b0;
        tick(); tick();
        check("F_idle", {31'd0, busy}, 32'd0);
        check("F_all_delivered", exp_idx, wr_ptr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the width of a FIFO word and of the stream data.
REQ-002 Parameter CNT_WIDTH, default 16, is the width of the transfer counter.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset; it is synchronous and active-high.
REQ-005 Port en  input  1  enables reading; low requests a graceful drain.
REQ-006 Port fifo_empty  input  1  is the empty flag from the upstream synchronous FIFO.
REQ-007 Port fifo_rd_en  output  1  is the FIFO read strobe, one word per cycle high.
REQ-008 Port fifo_data  input  DATA_WIDTH  is the FIFO read data, valid the cycle after the edge that sampled fifo_rd_en high.
REQ-009 Port m_valid  output  1  indicates that m_data holds a word for downstream.
REQ-010 Port m_ready  input  1  indicates that downstream accepts; a transfer occurs when m_valid and m_ready are both high at an edge.
REQ-011 Port m_data  output  DATA_WIDTH  is the stream data, the oldest buffered word.
REQ-012 Port busy  output  1  is high whenever the state is not IDLE.
REQ-013 Port xfer_count  output  CNT_WIDTH  counts completed stream transfers.

Function
REQ-014 The block SHALL hold a 2-entry in-order buffer with occupancy occ (0..2) and a 1-bit inflight flag, which is set the cycle after fifo_rd_en is high.
REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN: IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->RUN when en=1; DRAIN->IDLE when occ=0 and inflight=0.
REQ-016 The block SHALL drive fifo_rd_en = (state==RUN) && !fifo_empty && (occ + inflight - pop) < 2, where pop = m_valid && m_ready; this path is combinational from m_ready and fifo_empty.
REQ-017 fifo_rd_en SHALL never be high in IDLE or DRAIN, and never while rst is high.
REQ-018 When inflight=1, the block SHALL capture fifo_data at the edge into the tail of the buffer; it SHALL never drop a word or overflow (occ never exceeds 2).
REQ-019 m_valid SHALL equal (occ != 0) and m_data SHALL be the head entry, both driven from registers.
REQ-020 On a simultaneous capture and pop, the block SHALL keep occ unchanged and preserve word order.
REQ-021 Latency SHALL be 2 cycles from fifo_rd_en high to the word appearing on m_valid/m_data when the buffer is empty.
REQ-022 Sustained throughput SHALL be one word per cycle while the FIFO is non-empty and m_ready=1.
REQ-023 While m_valid=1 and m_ready=0, m_data SHALL stay stable.
REQ-024 xfer_count SHALL increment by 1 on each transfer and wrap from 2^CNT_WIDTH-1 to 0.
REQ-025 fifo_empty SHALL be sampled only in RUN; the block SHALL assume nothing about FIFO contents beyond the flag.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set the state to IDLE, occ=0, inflight=0, m_valid=0, m_data=0, busy=0 and xfer_count=0.
REQ-027 A reset mid-operation SHALL discard buffered and in-flight words; any word already removed from the FIFO is lost, and FIFO pointers are not touched by this block.

Verification
REQ-028 FIFO preloaded with 0xA0..0xA7, en=1, m_ready=1 -> first m_valid 3 cycles after en rises; 8 consecutive transfers A0..A7 in order; xfer_count=8; fifo_rd_en low once fifo_empty=1.
REQ-029 FIFO holds 5 words, m_ready=0 -> exactly 2 reads are issued, occ=2, m_data stable at the first word; m_ready=1 -> remaining 3 words follow with no gaps or duplicates.
REQ-030 en deasserted while occ=2 with 4 words left in the FIFO -> no further fifo_rd_en; 2 buffered words are delivered; state goes DRAIN->IDLE; busy=0; 4 words remain in the FIFO.
REQ-031 m_ready toggling 1,0,1,0 with the FIFO continuously fed -> data order is preserved; occ never exceeds 2; transfer count matches the number of handshakes.
REQ-032 rst asserted one cycle after fifo_rd_en with inflight=1 and occ=1 -> next cycle m_valid=0, busy=0, xfer_count=0, fifo_rd_en=0.
REQ-033 xfer_count preset by running 65535 transfers, then one more -> xfer_count=0.
